// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_restoring_divider #(parameter int BW = 8) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_start,
  input  logic [BW-1:0] i_dividend,
  input  logic [BW-1:0] i_divisor,
  output logic          o_busy,
  output logic          o_valid,
  output logic [BW-1:0] o_quotient,
  output logic [BW-1:0] o_remainder,
  output logic          o_div_by_zero,
  output logic [50:0]   number
);
  localparam int CW = $clog2(BW);
  localparam logic [CW-1:0] LAST = CW'(BW - 1);
  localparam int CELLS = 2 * (BW + 1) + (5 * BW + CW + 4) + 6;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_p, r_dvd, r_dvs;
  logic [BW:0] w_p, w_t;
  logic w_accept, w_ge, w_last;
  assign w_accept = i_start && r_state != RUN;
  assign w_last = r_cnt == LAST;
  assign w_p = {r_p, r_dvd[BW-1]};
  assign w_t = w_p - {1'b0, r_dvs};
  // P < 2*divisor, so the (BW+1)-bit difference's sign bit is exactly the borrow
  assign w_ge = !w_t[BW];
  assign o_busy = r_state == RUN;
  assign number = 51'(CELLS);
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = i_divisor != '0 ? RUN : DONE;
    else if (r_state == RUN) w_next = w_last ? DONE : RUN;
    else if (r_state == DONE) w_next = IDLE;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) r_state <= IDLE;
    else r_state <= w_next;
  // quotient bits shift into the low end of the dividend register as its bits are consumed
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      r_cnt <= '0;
      r_p <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      o_valid <= 1'b0;
      o_quotient <= '0;
      o_remainder <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (w_accept) begin
        r_dvd <= i_dividend;
        r_dvs <= i_divisor;
        r_p <= '0;
        r_cnt <= '0;
        if (i_divisor == '0) begin
          o_quotient <= '1;
          o_remainder <= i_dividend;
          o_div_by_zero <= 1'b1;
          o_valid <= 1'b1;
        end
      end else if (r_state == RUN) begin
        r_p <= w_ge ? w_t[BW-1:0] : w_p[BW-1:0];
        r_dvd <= {r_dvd[BW-2:0], w_ge};
        r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
        if (w_last) begin
          o_quotient <= {r_dvd[BW-2:0], w_ge};
          o_remainder <= w_ge ? w_t[BW-1:0] : w_p[BW-1:0];
          o_div_by_zero <= 1'b0;
          o_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench running BW=8 and BW=16 instances against a plain-arithmetic model.
module tb_seq_restoring_divider;
  logic clk = 1'b0;
  longint cyc = 0;
  int total = 0, pass = 0;
  logic done [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got == exp) pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = g ? 16 : 8;
    localparam longint M = (64'd1 << W) - 1;
    logic rst_n, start, busy, valid, dbz;
    logic [W-1:0] dvd, dvs, quo, rem;
    logic [50:0] num;
    longint eq[$], er[$], ed[$], ec[$], eb[$], ea[$], ev[$];
    seq_restoring_divider #(.BW(W)) dut (
      .CLK(clk), .RESET(rst_n), .i_start(start), .i_dividend(dvd), .i_divisor(dvs),
      .o_busy(busy), .o_valid(valid), .o_quotient(quo), .o_remainder(rem),
      .o_div_by_zero(dbz), .number(num)
    );
    task automatic issue(input longint a, input longint b);
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (busy) chk("busy_timeout", 1, 0);
      dvd = W'(a);
      dvs = W'(b);
      start = 1'b1;
      eq.push_back(b == 0 ? M : a / b);
      er.push_back(b == 0 ? a : a % b);
      ed.push_back(b == 0 ? 1 : 0);
      ec.push_back(cyc + 1 + (b == 0 ? 0 : W));
      eb.push_back(b == 0 ? 0 : W);
      ea.push_back(a);
      ev.push_back(b);
      @(posedge clk);
      #1 start = 1'b0;
    endtask
    initial begin
      logic [2*W:0] prev;
      logic [50:0] n0;
      longint bc, a, b;
      bc = 0;
      prev = '0;
      n0 = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          bc = 0;
          prev = '0;
          n0 = num;
          continue;
        end
        if (busy) bc++;
        if (valid) begin
          if (eq.size() == 0) chk("unexpected_valid", 1, 0);
          else begin
            chk("quotient", longint'(quo), eq.pop_front());
            chk("remainder", longint'(rem), er.pop_front());
            chk("div_by_zero", longint'(dbz), ed.pop_front());
            chk("latency", cyc, ec.pop_front());
            chk("busy_cycles", bc, eb.pop_front());
            a = ea.pop_front();
            b = ev.pop_front();
            if (b != 0) begin
              chk("invariant", longint'(quo) * b + longint'(rem), a);
              chk("rem_lt_div", longint'(longint'(rem) < b), 1);
            end
            chk("number_const", longint'(num), longint'(n0));
          end
          bc = 0;
        end else chk("hold", longint'({quo, rem, dbz}), longint'(prev));
        prev = {quo, rem, dbz};
      end
    end
    initial begin
      longint a, b;
      int n, r;
      done[g] = 1'b0;
      rst_n = 1'b0;
      start = 1'b0;
      dvd = '0;
      dvs = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("number_nonzero", longint'(num != 0), 1);
      issue(100, 7);
      issue(255, 1);
      issue(5, 9);
      issue(42, 0);
      issue(9, 3);
      issue(200, 13);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", longint'(busy), 0);
      chk("rst_valid", longint'(valid), 0);
      chk("rst_quotient", longint'(quo), 0);
      chk("rst_remainder", longint'(rem), 0);
      chk("rst_dbz", longint'(dbz), 0);
      eq.delete(); er.delete(); ed.delete(); ec.delete(); eb.delete(); ea.delete(); ev.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(200, 13);
      issue(77, 5);
      repeat (3) @(negedge clk);
      start = 1'b1;
      dvd = W'(10);
      dvs = W'(2);
      @(negedge clk);
      start = 1'b0;
      dvd = W'($urandom);
      dvs = '0;
      for (int i = 0; i < 1000; i++) begin
        r = $urandom_range(0, 7);
        a = longint'($urandom) & M;
        b = r == 0 ? 0 : r == 1 ? longint'($urandom_range(1, 3)) : longint'($urandom) & M;
        issue(a, b);
      end
      n = 0;
      while (eq.size() != 0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("drain", longint'(eq.size()), 0);
      done[g] = 1'b1;
    end
  end
  initial begin
    int n = 0;
    #1;
    while (!(done[0] && done[1]) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    chk("finished", longint'(done[0] && done[1]), 1);
    chk("number_grows", longint'(u[1].num > u[0].num), 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
